// File: rtl/mac_log_encode_if.sv
// Handshake bundle for the linear-to-log encoder: input stream, output stream
// and saturation counter sideband.
interface mac_log_encode_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned IN_WIDTH   = 2**DATA_WIDTH + 6,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_code;
  logic                  out_zero;
  logic                  out_sat;
  logic [CNT_WIDTH-1:0]  sat_count;
  logic                  sat_clear;

  modport master (
    output in_valid, in_data, out_ready, sat_clear,
    input  in_ready, out_valid, out_code, out_zero, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, sat_clear,
    output in_ready, out_valid, out_code, out_zero, out_sat, sat_count
  );
endinterface

// File: rtl/mac_log_encode.sv
// Streaming linear-to-log encoder: two-stage pipeline turning a signed linear
// value into {sign, exp} with round-to-nearest power of two and saturation.
module mac_log_encode #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned IN_WIDTH   = 2**DATA_WIDTH + 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  mac_log_encode_if.slave bus
);
  localparam int unsigned EXP_W   = DATA_WIDTH - 1;
  localparam int unsigned EXP_MAX = 2**EXP_W - 1;
  localparam int unsigned POS_W   = $clog2(IN_WIDTH) + 1;

  logic                  s1_valid_q;
  logic                  s1_sign_q;
  logic [IN_WIDTH-1:0]   s1_mag_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_code_q, out_code_d;
  logic                  out_zero_q, out_zero_d;
  logic                  out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]  sat_count_q, sat_count_d;

  logic                  s1_adv;
  logic                  s2_adv;
  logic [IN_WIDTH-1:0]   in_mag;
  logic [IN_WIDTH-1:0]   mag_below;
  logic [POS_W-1:0]      lead_pos;
  logic [POS_W-1:0]      exp_raw;
  logic                  round_up;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Unsigned magnitude; the most negative input maps to 2^(IN_WIDTH-1).
  assign in_mag = bus.in_data[IN_WIDTH-1] ? (~bus.in_data) + IN_WIDTH'(1) : bus.in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q <= bus.in_data[IN_WIDTH-1];
        s1_mag_q  <= in_mag;
      end
    end
  end

  // mag_below[i] is the bit just under position i, i.e. the rounding bit.
  assign mag_below = s1_mag_q << 1;

  always_comb begin
    lead_pos   = '0;
    round_up   = 1'b0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag_q[i]) begin
        lead_pos = POS_W'(i);
        round_up = mag_below[i];
      end
    end
    exp_raw    = lead_pos + POS_W'(round_up);
    out_zero_d = (s1_mag_q == '0);
    out_sat_d  = !out_zero_d && (exp_raw > POS_W'(EXP_MAX));
    out_code_d = '0;
    if (!out_zero_d) begin
      out_code_d = {s1_sign_q, out_sat_d ? EXP_W'(EXP_MAX) : exp_raw[EXP_W-1:0]};
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (bus.sat_clear) begin
      sat_count_d = '0;
    end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_zero_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_code_q <= out_code_d;
          out_zero_q <= out_zero_d;
          out_sat_q  <= out_sat_d;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_count = sat_count_q;
endmodule
